// File: rtl/connect4_board_pkg.sv
// Shared definitions for the connect-four board slice: board geometry, the
// game-control FSM state codes driven into the board, the status codes the
// board reports back, cell encodings, the board's own sequencer states and a
// bounds-checked cell read helper used by both the display port and the
// win scanner.
package connect4_board_pkg;

  localparam int COLS    = 7;
  localparam int ROWS    = 6;
  localparam int WIN_LEN = 4;
  localparam int CELLS   = COLS * ROWS;

  typedef enum logic [1:0] {
    GAME_INIT = 2'b00,
    P1_TURN   = 2'b01,
    P2_TURN   = 2'b10,
    END_GAME  = 2'b11
  } fsm_state_e;

  typedef enum logic [1:0] {
    NEXT_TURN  = 2'b00,
    PLAYER_WIN = 2'b01,
    TIE_GAME   = 2'b10
  } game_status_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLACE,
    S_CHECK,
    S_REPORT,
    S_DONE
  } brd_state_e;

  // Column-major board: board[col][row], row 0 is the bottom.
  typedef logic [COLS-1:0][ROWS-1:0][1:0] board_t;

  // Out-of-range addresses read as EMPTY so callers never index past the array.
  function automatic logic [1:0] cell_at(input board_t b, input logic [2:0] c,
                                         input logic [2:0] r);
    if (c < 3'(COLS) && r < 3'(ROWS)) return b[c][r];
    return EMPTY;
  endfunction

endpackage

// File: rtl/connect4_win_scan.sv
// Fixed-length four-in-a-row scanner around the most recently placed piece.
// Walks horizontal, vertical, diagonal (+1,+1) and anti-diagonal (+1,-1),
// seven probes each at offsets -3..+3, one probe per cycle (28 cycles).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start_i             one-cycle pulse: begin a new scan, clear run/win
//   col_i, row_i        centre of the scan (placed piece)
//   player_i            cell code being searched for
//   cell_i              board value at probe_col_o/probe_row_o (from parent)
//   probe_col_o/row_o   current probe address (valid when probe_on_o)
//   probe_on_o          probe address lies on the board
//   done_o              high during the final probe cycle
//   win_o               a run of WIN_LEN was seen, including the current probe
module connect4_win_scan
  import connect4_board_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [2:0] col_i,
  input  logic [2:0] row_i,
  input  logic [1:0] player_i,
  input  logic [1:0] cell_i,
  output logic [2:0] probe_col_o,
  output logic [2:0] probe_row_o,
  output logic       probe_on_o,
  output logic       done_o,
  output logic       win_o
);

  localparam logic signed [3:0] COLS_S = 4'(COLS);
  localparam logic signed [3:0] ROWS_S = 4'(ROWS);

  logic              active_q;
  logic [1:0]        dir_q;
  logic [2:0]        off_q;
  logic [2:0]        run_q;
  logic              win_q;

  logic signed [3:0] off_s, dc, dr, pc, pr;
  logic [2:0]        run_base, run_d;
  logic              hit;

  always_comb begin
    off_s = $signed({1'b0, off_q}) - 4'sd3;
    dc    = 4'sd0;
    dr    = 4'sd0;
    case (dir_q)
      2'd0:    dc = off_s;
      2'd1:    dr = off_s;
      2'd2:    begin dc = off_s; dr = off_s;  end
      default: begin dc = off_s; dr = -off_s; end
    endcase
    // 4-bit signed coordinates: centre 0..6 plus -3..+3 can reach 8 or 9,
    // which wrap negative and so still land off-board.
    pc = $signed({1'b0, col_i}) + dc;
    pr = $signed({1'b0, row_i}) + dr;
    probe_on_o  = (pc >= 4'sd0) && (pc < COLS_S) && (pr >= 4'sd0) && (pr < ROWS_S);
    probe_col_o = pc[2:0];
    probe_row_o = pr[2:0];

    run_base = (off_q == 3'd0) ? 3'd0 : run_q;
    hit      = probe_on_o && (cell_i == player_i);
    run_d    = hit ? run_base + 3'd1 : 3'd0;

    done_o = active_q && (dir_q == 2'd3) && (off_q == 3'd6);
    win_o  = win_q || (active_q && run_d >= 3'(WIN_LEN));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      dir_q    <= 2'd0;
      off_q    <= 3'd0;
      run_q    <= 3'd0;
      win_q    <= 1'b0;
    end else if (start_i) begin
      active_q <= 1'b1;
      dir_q    <= 2'd0;
      off_q    <= 3'd0;
      run_q    <= 3'd0;
      win_q    <= 1'b0;
    end else if (active_q) begin
      run_q <= run_d;
      if (run_d >= 3'(WIN_LEN)) win_q <= 1'b1;
      if (off_q == 3'd6) begin
        off_q <= 3'd0;
        dir_q <= dir_q + 2'd1;
        if (dir_q == 2'd3) active_q <= 1'b0;
      end else begin
        off_q <= off_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/connect4_board.sv
// Connect-four board keeper sitting in front of the game-control FSM.
// Accepts column drops on the player's turn, stacks pieces with gravity,
// refuses full or out-of-range columns, then runs a 28-cycle win scan and
// reports the move outcome for exactly one cycle.
// Ports:
//   clk, reset       clock, synchronous active-high reset (clears the board)
//   current_state    FSM state: 00 init, 01 P1 turn, 10 P2 turn, 11 end
//   drop_valid       one-cycle drop request, drop_col = requested column
//   invalid_column   low only for the cycle reporting a completed legal move
//   in_game_status   00 next turn, 01 player win, 10 tie (sticky once decided)
//   busy             high while a drop is being placed/checked/reported
//   drop_reject      one-cycle pulse when a drop is refused
//   rd_col, rd_row   display read address; rd_cell is the combinational cell
module connect4_board
  import connect4_board_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] current_state,
  input  logic       drop_valid,
  input  logic [2:0] drop_col,
  output logic       invalid_column,
  output logic [1:0] in_game_status,
  output logic       busy,
  output logic       drop_reject,
  input  logic [2:0] rd_col,
  input  logic [2:0] rd_row,
  output logic [1:0] rd_cell
);

  brd_state_e           state_q;
  board_t               board_q;
  logic [COLS-1:0][2:0] height_q;
  logic [5:0]           count_q;
  logic [2:0]           col_q, row_q;
  logic [1:0]           player_q;
  logic                 invalid_column_q;
  logic [1:0]           status_q;
  logic                 reject_q;

  logic [2:0]           cur_h;
  logic                 legal;
  logic                 scan_start, scan_done, scan_win, probe_on;
  logic [2:0]           probe_col, probe_row;
  logic [1:0]           probe_cell;

  always_comb begin
    // An out-of-range column reads as full, which folds both refusal cases
    // into a single height test.
    cur_h      = (col_q < 3'(COLS)) ? height_q[col_q] : 3'(ROWS);
    legal      = (cur_h != 3'(ROWS));
    scan_start = (state_q == S_PLACE) && legal;
    probe_cell = probe_on ? cell_at(board_q, probe_col, probe_row) : EMPTY;
  end

  connect4_win_scan u_scan (
    .clk         (clk),
    .reset       (reset),
    .start_i     (scan_start),
    .col_i       (col_q),
    .row_i       (row_q),
    .player_i    (player_q),
    .cell_i      (probe_cell),
    .probe_col_o (probe_col),
    .probe_row_o (probe_row),
    .probe_on_o  (probe_on),
    .done_o      (scan_done),
    .win_o       (scan_win)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      board_q          <= '0;
      height_q         <= '0;
      count_q          <= 6'd0;
      col_q            <= 3'd0;
      row_q            <= 3'd0;
      player_q         <= EMPTY;
      invalid_column_q <= 1'b1;
      status_q         <= NEXT_TURN;
      reject_q         <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (drop_valid && (current_state == P1_TURN || current_state == P2_TURN)) begin
            col_q    <= drop_col;
            player_q <= (current_state == P1_TURN) ? P1 : P2;
            state_q  <= S_PLACE;
          end
        end
        S_PLACE: begin
          if (legal) begin
            board_q[col_q][cur_h] <= player_q;
            row_q                 <= cur_h;
            height_q[col_q]       <= cur_h + 3'd1;
            count_q               <= count_q + 6'd1;
            state_q               <= S_CHECK;
          end else begin
            reject_q <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        S_CHECK: begin
          // Outcome is latched only on the final probe, so a reset mid-scan
          // can never leak a partial result.
          if (scan_done) begin
            invalid_column_q <= 1'b0;
            if (scan_win)                    status_q <= PLAYER_WIN;
            else if (count_q == 6'(CELLS))   status_q <= TIE_GAME;
            else                             status_q <= NEXT_TURN;
            state_q <= S_REPORT;
          end
        end
        S_REPORT: begin
          invalid_column_q <= 1'b1;
          state_q <= (status_q != NEXT_TURN) ? S_DONE : S_IDLE;
        end
        S_DONE: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign invalid_column = invalid_column_q;
  assign in_game_status = status_q;
  assign drop_reject    = reject_q;
  assign busy           = (state_q == S_PLACE) || (state_q == S_CHECK) || (state_q == S_REPORT);
  assign rd_cell        = cell_at(board_q, rd_col, rd_row);

endmodule

// File: tb/tb_connect4_board.sv
// Directed bench for connect4_board. A reference board model computes the
// expected outcome of each drop (brute-force four-in-a-row search over the
// whole board); expected statuses go through a scoreboard queue and are
// compared when the DUT reports.
module tb_connect4_board;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] current_state;
  logic       drop_valid;
  logic [2:0] drop_col;
  logic       invalid_column;
  logic [1:0] in_game_status;
  logic       busy;
  logic       drop_reject;
  logic [2:0] rd_col, rd_row;
  logic [1:0] rd_cell;

  int errors = 0;
  int checks = 0;

  logic [1:0] mb [7][6];
  int         mh [7];
  int         mcount;
  logic [1:0] cur;
  int         sb [$];
  int         seq [$];

  connect4_board dut (
    .clk            (clk),
    .reset          (reset),
    .current_state  (current_state),
    .drop_valid     (drop_valid),
    .drop_col       (drop_col),
    .invalid_column (invalid_column),
    .in_game_status (in_game_status),
    .busy           (busy),
    .drop_reject    (drop_reject),
    .rd_col         (rd_col),
    .rd_row         (rd_row),
    .rd_cell        (rd_cell)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 7; c++) begin
      mh[c] = 0;
      for (int r = 0; r < 6; r++) mb[c][r] = 2'b00;
    end
    mcount = 0;
    cur    = 2'b01;
  endtask

  function automatic bit model_win(input logic [1:0] p);
    int dc [4];
    int dr [4];
    dc = '{1, 0, 1, 1};
    dr = '{0, 1, 1, -1};
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        for (int d = 0; d < 4; d++) begin
          bit ok;
          ok = 1'b1;
          for (int k = 0; k < 4; k++) begin
            int cc, rr;
            cc = c + dc[d] * k;
            rr = r + dr[d] * k;
            if (cc < 0 || cc >= 7 || rr < 0 || rr >= 6) ok = 1'b0;
            else if (mb[cc][rr] !== p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  task automatic do_reset();
    drop_valid    = 1'b0;
    current_state = 2'b00;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_board(input string tag);
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        rd_col = 3'(c);
        rd_row = 3'(r);
        #1;
        chk($sformatf("%s_c%0d_r%0d", tag, c, r), rd_cell, mb[c][r]);
      end
    @(posedge clk); #1;
  endtask

  task automatic play(input int col);
    bit rej, sawrej;
    int exp_st, lat;
    rej = 1'b0;
    if (col >= 7) rej = 1'b1;
    else if (mh[col] == 6) rej = 1'b1;
    current_state = cur;
    drop_col      = 3'(col);
    drop_valid    = 1'b1;
    @(posedge clk); #1;
    drop_valid = 1'b0;
    chk("busy_place", busy, 1);
    if (rej) begin
      @(posedge clk); #1;
      chk("reject_pulse", drop_reject, 1);
      chk("reject_invalid", invalid_column, 1);
      chk("reject_busy", busy, 0);
      @(posedge clk); #1;
      chk("reject_width", drop_reject, 0);
    end else begin
      mb[col][mh[col]] = cur;
      mh[col]++;
      mcount++;
      exp_st = model_win(cur) ? 1 : (mcount == 42 ? 2 : 0);
      sb.push_back(exp_st);
      lat = 0;
      sawrej = 1'b0;
      while (invalid_column !== 1'b0 && lat < 40) begin
        @(posedge clk); #1;
        lat++;
        if (drop_reject !== 1'b0) sawrej = 1'b1;
      end
      chk("report_latency", lat, 29);
      chk("report_status", in_game_status, sb.pop_front());
      chk("no_reject", sawrej, 0);
      @(posedge clk); #1;
      chk("report_width", invalid_column, 1);
      chk("status_after", in_game_status, exp_st);
      chk("busy_after", busy, 0);
      if (exp_st == 0) cur = (cur == 2'b01) ? 2'b10 : 2'b01;
    end
  endtask

  task automatic run_seq();
    foreach (seq[i]) play(seq[i]);
  endtask

  task automatic ignored(input logic [1:0] st, input logic [1:0] exp_status);
    current_state = st;
    drop_col      = 3'd3;
    drop_valid    = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("ign_busy", busy, 0);
      chk("ign_reject", drop_reject, 0);
      chk("ign_status", in_game_status, exp_status);
      chk("ign_invalid", invalid_column, 1);
    end
    drop_valid = 1'b0;
  endtask

  task automatic tie_rows(input bool_last_wins);
    int base [7];
    int last [7];
    base = '{0, 2, 1, 3, 4, 6, 5};
    last = '{0, 4, 1, 5, 2, 6, 3};
    seq.delete();
    for (int r = 0; r < 6; r++)
      for (int i = 0; i < 7; i++)
        seq.push_back((r == 5 && bool_last_wins != 0) ? last[i] : base[i]);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    drop_valid = 1'b0;
    current_state = 2'b00;
    drop_col = 3'd0;
    rd_col = 3'd0;
    rd_row = 3'd0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_invalid", invalid_column, 1);
    chk("rst_status", in_game_status, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reject", drop_reject, 0);
    check_board("rst_board");

    // First move, display port and out-of-range reads
    play(3);
    rd_col = 3'd3; rd_row = 3'd0; #1;
    chk("rd_3_0", rd_cell, 1);
    rd_col = 3'd7; #1;
    chk("rd_oob_col", rd_cell, 0);
    rd_col = 3'd3; rd_row = 3'd6; #1;
    chk("rd_oob_row6", rd_cell, 0);
    rd_row = 3'd7; #1;
    chk("rd_oob_row7", rd_cell, 0);

    // Full column, repeated overflow, column 7, ignored FSM states
    do_reset();
    seq = '{0, 0, 0, 0, 0, 0, 0, 0, 7};
    run_seq();
    check_board("fullcol");
    ignored(2'b00, 2'b00);
    ignored(2'b11, 2'b00);

    // Horizontal four, then DONE holds and ignores drops
    do_reset();
    seq = '{0, 0, 1, 1, 2, 2, 3};
    run_seq();
    ignored(2'b10, 2'b01);
    check_board("horiz");

    // Vertical four
    do_reset();
    seq = '{0, 1, 0, 1, 0, 1, 0};
    run_seq();
    ignored(2'b01, 2'b01);

    // Diagonal (+1,+1)
    do_reset();
    seq = '{0, 1, 1, 2, 3, 2, 2, 3, 6, 3, 3};
    run_seq();

    // Anti-diagonal (+1,-1)
    do_reset();
    seq = '{6, 5, 5, 4, 3, 4, 4, 3, 0, 3, 3};
    run_seq();

    // Run of three broken by an opponent piece
    do_reset();
    seq = '{0, 3, 1, 6, 2, 6, 4};
    run_seq();
    check_board("broken");

    // Pieces at the top of column 0 and bottom of column 1 must not join
    do_reset();
    seq = '{1, 0, 6, 0, 5, 0, 0, 6, 0, 5, 0};
    run_seq();

    // Full board, no four: tie held in DONE
    do_reset();
    tie_rows(0);
    run_seq();
    ignored(2'b01, 2'b10);
    check_board("tie");

    // Full board where the 42nd piece wins: win beats tie
    do_reset();
    tie_rows(1);
    run_seq();
    ignored(2'b10, 2'b01);

    // Reset mid-CHECK: clean reset values, empty board, no late report
    do_reset();
    current_state = 2'b01;
    drop_col = 3'd4;
    drop_valid = 1'b1;
    @(posedge clk); #1;
    drop_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_invalid", invalid_column, 1);
    chk("midrst_status", in_game_status, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_reject", drop_reject, 0);
    rd_col = 3'd4; rd_row = 3'd0; #1;
    chk("midrst_cell", rd_cell, 0);
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (invalid_column !== 1'b1 || in_game_status !== 2'b00 || busy !== 1'b0) bad++;
    end
    chk("midrst_no_partial", bad, 0);
    model_clear();
    check_board("midrst_board");
    play(4);
    rd_col = 3'd4; rd_row = 3'd0; #1;
    chk("after_rst_cell", rd_cell, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
